// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// debug cause codes and the width of the stall/flush hold counter.
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_pkg;

   // Hold counter must represent up to 7 extra cycles.
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_FLUSHING   = 2'd2
   } hazard_state_e;

   localparam logic [3:0] CAUSE_NONE   = 4'h0;
   localparam logic [3:0] CAUSE_LOAD   = 4'h1;
   localparam logic [3:0] CAUSE_BRANCH = 4'hB;
   localparam logic [3:0] CAUSE_FLUSH  = 4'hF;

endpackage

// File: rtl/hazard_ctrl_unit_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational load-use comparator: flags when a load in a later stage writes
// a register that the ID instruction actually reads. x0 never matches.
// Ports:
//   rs1_i, rs2_i           ID source register addresses
//   rs1_used_i, rs2_used_i ID instruction really reads rs1 / rs2
//   rd_i                   destination of the older instruction
//   load_i                 older instruction is a load
//   hit_o                  load-use dependency present
// -----------------------------------------------------------------------------
module hazard_match
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   input  logic              rs1_used_i,
   input  logic              rs2_used_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic              load_i,
   output logic              hit_o
);

   assign hit_o = load_i & (rd_i != '0) &
                  ((rs1_used_i & (rs1_i == rd_i)) |
                   (rs2_used_i & (rs2_i == rd_i)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
// ID-stage hazard controller for the 5-stage RISC-V pipeline. Detects load-use
// hazards against EX (and MEM when CHECK_MEM=1), holds multi-cycle load stalls
// and taken-branch flushes in a small FSM, and stalls while an unresolved
// branch sits in ID.
//
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating 32-bit cycle
// counters perf_stall_cnt / perf_branch_cnt / perf_flush_cnt.
//
// Ports:
//   clock, reset          clock; asynchronous active-high reset
//   rs1_ID, rs2_ID        ID source registers, with rs1_used_ID / rs2_used_ID
//   rd_EX, load_EX        EX destination / EX is a load
//   rd_MEM, load_MEM      MEM destination / MEM is a load
//   branch_ID             unresolved branch/jump in ID
//   branch_taken          branch resolved taken this cycle
//   stall_IFID            hold IF/ID and PC
//   stall_IDEX            hold ID/EX / insert bubble
//   flush                 squash IF/ID and ID/EX
//   cause                 debug cause (none/load/branch/flush)
//   busy                  FSM not in IDLE
// -----------------------------------------------------------------------------
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int LOAD_EXTRA  = 2,
   parameter int FLUSH_EXTRA = 0,
   parameter int CHECK_MEM   = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs1_ID,
   input  logic [REG_AW-1:0] rs2_ID,
   input  logic              rs1_used_ID,
   input  logic              rs2_used_ID,
   input  logic [REG_AW-1:0] rd_EX,
   input  logic              load_EX,
   input  logic [REG_AW-1:0] rd_MEM,
   input  logic              load_MEM,
   input  logic              branch_ID,
   input  logic              branch_taken,
   output logic              stall_IFID,
   output logic              stall_IDEX,
   output logic              flush,
   output logic [3:0]        cause,
   output logic              busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_branch_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_EXTRA);
   localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_EXTRA);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   hazard_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic hit_ex, hit_mem_raw, hit_mem, lu;

   hazard_match #(.REG_AW(REG_AW)) u_match_ex (
      .rs1_i      (rs1_ID),
      .rs2_i      (rs2_ID),
      .rs1_used_i (rs1_used_ID),
      .rs2_used_i (rs2_used_ID),
      .rd_i       (rd_EX),
      .load_i     (load_EX),
      .hit_o      (hit_ex)
   );

   hazard_match #(.REG_AW(REG_AW)) u_match_mem (
      .rs1_i      (rs1_ID),
      .rs2_i      (rs2_ID),
      .rs1_used_i (rs1_used_ID),
      .rs2_used_i (rs2_used_ID),
      .rd_i       (rd_MEM),
      .load_i     (load_MEM),
      .hit_o      (hit_mem_raw)
   );

   // MEM comparison only matters when the pipeline lacks MEM->EX load forwarding.
   assign hit_mem = hit_mem_raw & (CHECK_MEM != 0);
   assign lu      = hit_ex | hit_mem;

   // Output priority: taken branch > load stall > flush hold > branch-in-ID.
   // Reset forces everything low even before the flops are cleared.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      stall_IFID = 1'b0;
      stall_IDEX = 1'b0;
      flush      = 1'b0;
      cause      = CAUSE_NONE;
      if (!reset) begin
         if (branch_taken) begin
            flush = 1'b1;
            cause = CAUSE_FLUSH;
         end else if (lu || state_q == ST_LOAD_STALL) begin
            stall_IFID = 1'b1;
            stall_IDEX = 1'b1;
            cause      = CAUSE_LOAD;
         end else if (state_q == ST_FLUSHING) begin
            flush = 1'b1;
            cause = CAUSE_FLUSH;
         end else if (branch_ID) begin
            stall_IFID = 1'b1;
            stall_IDEX = 1'b1;
            cause      = CAUSE_BRANCH;
         end
      end
   end

   assign busy = (state_q != ST_IDLE) & ~reset;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (branch_taken) begin
         // A taken branch squashes whatever stall was pending.
         if (FLUSH_EXTRA > 0) begin
            state_d = ST_FLUSHING;
            cnt_d   = FLUSH_RELOAD;
         end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (lu && LOAD_EXTRA > 0) begin
                  state_d = ST_LOAD_STALL;
                  cnt_d   = LOAD_RELOAD;
               end
            end
            ST_LOAD_STALL: begin
               // A fresh hazard restarts the hold rather than extending it.
               if (lu) begin
                  cnt_d = LOAD_RELOAD;
               end else if (cnt_q == CNT_ONE) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            ST_FLUSHING: begin
               if (cnt_q == CNT_ONE) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_q, perf_branch_q, perf_flush_q;

   // Counters saturate instead of wrapping so long runs stay meaningful.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_stall_q  <= '0;
         perf_branch_q <= '0;
         perf_flush_q  <= '0;
      end else begin
         if (cause == CAUSE_LOAD && perf_stall_q != '1)
            perf_stall_q <= perf_stall_q + 32'd1;
         if (cause == CAUSE_BRANCH && perf_branch_q != '1)
            perf_branch_q <= perf_branch_q + 32'd1;
         if (cause == CAUSE_FLUSH && perf_flush_q != '1)
            perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall_cnt  = perf_stall_q;
   assign perf_branch_cnt = perf_branch_q;
   assign perf_flush_cnt  = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
// Directed bench for hazard_ctrl_unit. Two instances share the stimulus:
//   dut_a: LOAD_EXTRA=2, FLUSH_EXTRA=1, CHECK_MEM=1
//   dut_b: LOAD_EXTRA=0, FLUSH_EXTRA=0, CHECK_MEM=0
// Observed vector per instance: {stall_IFID, stall_IDEX, flush, busy, cause}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

   localparam int AW = 5;

   // Hand-encoded expected vectors {stall_IFID, stall_IDEX, flush, busy, cause[3:0]}.
   localparam logic [7:0] E_IDLE = 8'h00; // nothing
   localparam logic [7:0] E_S1   = 8'hC1; // load stall, detect cycle (busy 0)
   localparam logic [7:0] E_SB   = 8'hD1; // load stall while FSM busy
   localparam logic [7:0] E_F0   = 8'h2F; // flush, FSM idle
   localparam logic [7:0] E_FB   = 8'h3F; // flush, FSM busy
   localparam logic [7:0] E_B    = 8'hCB; // branch-in-ID stall

   logic          clock, reset;
   logic [AW-1:0] rs1_ID, rs2_ID, rd_EX, rd_MEM;
   logic          rs1_used_ID, rs2_used_ID, load_EX, load_MEM;
   logic          branch_ID, branch_taken;

   logic       stall_IFID_a, stall_IDEX_a, flush_a, busy_a;
   logic [3:0] cause_a;
   logic       stall_IFID_b, stall_IDEX_b, flush_b, busy_b;
   logic [3:0] cause_b;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] pst_a, pbr_a, pfl_a, pst_b, pbr_b, pfl_b;
`endif

   wire [7:0] obs_a = {stall_IFID_a, stall_IDEX_a, flush_a, busy_a, cause_a};
   wire [7:0] obs_b = {stall_IFID_b, stall_IDEX_b, flush_b, busy_b, cause_b};

   int n_pass  = 0;
   int n_total = 0;

   hazard_ctrl_unit #(.REG_AW(AW), .LOAD_EXTRA(2), .FLUSH_EXTRA(1), .CHECK_MEM(1)) dut_a (
      .clock(clock), .reset(reset),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
      .rd_EX(rd_EX), .load_EX(load_EX), .rd_MEM(rd_MEM), .load_MEM(load_MEM),
      .branch_ID(branch_ID), .branch_taken(branch_taken),
      .stall_IFID(stall_IFID_a), .stall_IDEX(stall_IDEX_a), .flush(flush_a),
      .cause(cause_a), .busy(busy_a)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cnt(pst_a), .perf_branch_cnt(pbr_a), .perf_flush_cnt(pfl_a)
`endif
   );

   hazard_ctrl_unit #(.REG_AW(AW), .LOAD_EXTRA(0), .FLUSH_EXTRA(0), .CHECK_MEM(0)) dut_b (
      .clock(clock), .reset(reset),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
      .rd_EX(rd_EX), .load_EX(load_EX), .rd_MEM(rd_MEM), .load_MEM(load_MEM),
      .branch_ID(branch_ID), .branch_taken(branch_taken),
      .stall_IFID(stall_IFID_b), .stall_IDEX(stall_IDEX_b), .flush(flush_b),
      .cause(cause_b), .busy(busy_b)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cnt(pst_b), .perf_branch_cnt(pbr_b), .perf_flush_cnt(pfl_b)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      rs1_ID = '0; rs2_ID = '0; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
      rd_EX = '0; load_EX = 1'b0; rd_MEM = '0; load_MEM = 1'b0;
      branch_ID = 1'b0; branch_taken = 1'b0;
   endtask

   // Classic EX load-use hazard for one cycle.
   task automatic drive_lu_ex();
      clear_inputs();
      load_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; rs1_used_ID = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      branch_ID = 1'b1; branch_taken = 1'b1; drive_lu_ex();
      branch_ID = 1'b1; branch_taken = 1'b1;
      #3;
      n_total++;
      if (obs_a !== E_IDLE) $display("FAIL reset_a got %h want %h", obs_a, E_IDLE);
      else n_pass++;
      n_total++;
      if (obs_b !== E_IDLE) $display("FAIL reset_b got %h want %h", obs_b, E_IDLE);
      else n_pass++;
      @(posedge clock); #1;
      clear_inputs();
      reset = 1'b0;
      #2;
      n_total++;
      if (obs_a !== E_IDLE) $display("FAIL post_reset_a got %h want %h", obs_a, E_IDLE);
      else n_pass++;
      tick();
   endtask

   task automatic test_load_use();
      logic [7:0] ea [4];
      logic [7:0] eb [4];
      ea = '{E_S1, E_SB, E_SB, E_IDLE};
      eb = '{E_S1, E_IDLE, E_IDLE, E_IDLE};
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive_lu_ex(); else clear_inputs();
         #2;
         n_total++;
         if (obs_a !== ea[i]) $display("FAIL load_use_a cyc%0d got %h want %h", i, obs_a, ea[i]);
         else n_pass++;
         n_total++;
         if (obs_b !== eb[i]) $display("FAIL load_use_b cyc%0d got %h want %h", i, obs_b, eb[i]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_x0_unused();
      logic [7:0] ea [7];
      logic [7:0] eb [7];
      ea = '{E_IDLE, E_IDLE, E_IDLE, E_S1, E_SB, E_SB, E_IDLE};
      eb = '{E_IDLE, E_IDLE, E_IDLE, E_S1, E_IDLE, E_IDLE, E_IDLE};
      for (int i = 0; i < 7; i++) begin
         clear_inputs();
         case (i)
            0: begin // rd = x0 never stalls
               load_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0; rs1_used_ID = 1'b1;
               rs2_ID = 5'd0; rs2_used_ID = 1'b1;
            end
            1: begin // matching but unused operands
               load_EX = 1'b1; rd_EX = 5'd7; rs1_ID = 5'd7; rs2_ID = 5'd7;
            end
            2: begin // matching operand, but EX is not a load
               rd_EX = 5'd7; rs2_ID = 5'd7; rs2_used_ID = 1'b1;
            end
            3: begin // positive control via rs2
               load_EX = 1'b1; rd_EX = 5'd7; rs2_ID = 5'd7; rs2_used_ID = 1'b1;
            end
            default: ;
         endcase
         #2;
         n_total++;
         if (obs_a !== ea[i]) $display("FAIL x0_unused_a cyc%0d got %h want %h", i, obs_a, ea[i]);
         else n_pass++;
         n_total++;
         if (obs_b !== eb[i]) $display("FAIL x0_unused_b cyc%0d got %h want %h", i, obs_b, eb[i]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_branch_during_stall();
      logic [7:0] ea [4];
      logic [7:0] eb [4];
      ea = '{E_S1, E_FB, E_FB, E_IDLE};
      eb = '{E_S1, E_F0, E_IDLE, E_IDLE};
      for (int i = 0; i < 4; i++) begin
         if (i == 0) drive_lu_ex();
         else begin
            clear_inputs();
            if (i == 1) branch_taken = 1'b1;
         end
         #2;
         n_total++;
         if (obs_a !== ea[i]) $display("FAIL br_flush_a cyc%0d got %h want %h", i, obs_a, ea[i]);
         else n_pass++;
         n_total++;
         if (obs_b !== eb[i]) $display("FAIL br_flush_b cyc%0d got %h want %h", i, obs_b, eb[i]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_branch_stall_reset();
      for (int i = 0; i < 4; i++) begin
         clear_inputs();
         branch_ID = 1'b1;
         #2;
         n_total++;
         if (obs_a !== E_B) $display("FAIL br_stall_a cyc%0d got %h want %h", i, obs_a, E_B);
         else n_pass++;
         n_total++;
         if (obs_b !== E_B) $display("FAIL br_stall_b cyc%0d got %h want %h", i, obs_b, E_B);
         else n_pass++;
         tick();
      end
      // Enter a load stall, then hit reset in the middle of it.
      drive_lu_ex();
      tick();
      clear_inputs();
      branch_ID = 1'b1;
      #2;
      n_total++;
      if (obs_a !== E_SB) $display("FAIL load_over_branch_a got %h want %h", obs_a, E_SB);
      else n_pass++;
      n_total++;
      if (obs_b !== E_B) $display("FAIL branch_idle_b got %h want %h", obs_b, E_B);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if (obs_a !== E_IDLE) $display("FAIL mid_reset_a got %h want %h", obs_a, E_IDLE);
      else n_pass++;
      n_total++;
      if (obs_b !== E_IDLE) $display("FAIL mid_reset_b got %h want %h", obs_b, E_IDLE);
      else n_pass++;
      tick();
      clear_inputs();
      reset = 1'b0;
      #2;
      n_total++;
      if (obs_a !== E_IDLE) $display("FAIL after_reset_a got %h want %h", obs_a, E_IDLE);
      else n_pass++;
      tick();
   endtask

   task automatic test_mem_check();
      logic [7:0] ea [4];
      ea = '{E_S1, E_SB, E_SB, E_IDLE};
      for (int i = 0; i < 4; i++) begin
         clear_inputs();
         if (i == 0) begin
            load_MEM = 1'b1; rd_MEM = 5'd9; rs2_ID = 5'd9; rs2_used_ID = 1'b1;
         end
         #2;
         n_total++;
         if (obs_a !== ea[i]) $display("FAIL mem_a cyc%0d got %h want %h", i, obs_a, ea[i]);
         else n_pass++;
         n_total++;
         if (obs_b !== E_IDLE) $display("FAIL mem_b cyc%0d got %h want %h", i, obs_b, E_IDLE);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ea [6];
      logic [7:0] eb [6];
      ea = '{E_S1, E_SB, E_SB, E_SB, E_SB, E_IDLE};
      eb = '{E_S1, E_IDLE, E_S1, E_IDLE, E_IDLE, E_IDLE};
      for (int i = 0; i < 6; i++) begin
         if (i == 0 || i == 2) drive_lu_ex(); else clear_inputs();
         #2;
         n_total++;
         if (obs_a !== ea[i]) $display("FAIL b2b_a cyc%0d got %h want %h", i, obs_a, ea[i]);
         else n_pass++;
         n_total++;
         if (obs_b !== eb[i]) $display("FAIL b2b_b cyc%0d got %h want %h", i, obs_b, eb[i]);
         else n_pass++;
         tick();
      end
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf();
      clear_inputs();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
      n_total++;
      if (pst_a !== 32'd0) $display("FAIL perf_clear_a got %0d want 0", pst_a);
      else n_pass++;
      // Scenario: one load-use, drain, one taken branch, drain.
      for (int i = 0; i < 8; i++) begin
         clear_inputs();
         if (i == 0) drive_lu_ex();
         if (i == 4) branch_taken = 1'b1;
         tick();
      end
      n_total++;
      if (pst_a !== 32'd3) $display("FAIL perf_stall_a got %0d want 3", pst_a);
      else n_pass++;
      n_total++;
      if (pfl_a !== 32'd2) $display("FAIL perf_flush_a got %0d want 2", pfl_a);
      else n_pass++;
      n_total++;
      if (pbr_a !== 32'd0) $display("FAIL perf_branch_a got %0d want 0", pbr_a);
      else n_pass++;
      n_total++;
      if (pst_b !== 32'd1) $display("FAIL perf_stall_b got %0d want 1", pst_b);
      else n_pass++;
      n_total++;
      if (pfl_b !== 32'd1) $display("FAIL perf_flush_b got %0d want 1", pfl_b);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_x0_unused();
      test_branch_during_stall();
      test_branch_stall_reset();
      test_mem_check();
      test_back_to_back();
`ifdef HAZARD_PERF_CNT_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised hazard controller for the 5-stage RISC-V pipeline. It sits beside the ID stage and detects load-use hazards against EX and, optionally, MEM. It holds configurable multi-cycle stalls through a small FSM, handles branch-in-ID stalls, and issues taken-branch flushes. It drives the IF/ID and ID/EX stall/flush controls and a cause code for debug.

Parameters:
REG_AW, 5, register address width
LOAD_EXTRA, 2, stall cycles held after the load-use detect cycle (0..7)
FLUSH_EXTRA, 0, flush cycles held after the branch_taken cycle (0..7)
CHECK_MEM, 0, when 1 also stall on a load in MEM (for a pipeline without MEM->EX load forwarding)

Ports:
clock  in  1  pipeline clock
reset  in  1  asynchronous, active-high
rs1_ID  in  REG_AW  ID source 1
rs2_ID  in  REG_AW  ID source 2
rs1_used_ID  in  1  rs1 actually read by the ID instruction
rs2_used_ID  in  1  rs2 actually read by the ID instruction
rd_EX  in  REG_AW  EX destination
load_EX  in  1  EX instruction is a load (WB_sel=1)
rd_MEM  in  REG_AW  MEM destination
load_MEM  in  1  MEM instruction is a load
branch_ID  in  1  branch/jump in ID, not yet resolved
branch_taken  in  1  branch resolved taken this cycle
stall_IFID  out  1  hold IF/ID and PC
stall_IDEX  out  1  hold ID/EX / insert bubble
flush  out  1  squash IF/ID and ID/EX
cause  out  4  0x0 none, 0x1 load-use, 0xB branch, 0xF flush
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async): FSM=IDLE, counter=0. All outputs 0 while reset is high.
- hit_EX = load_EX & rd_EX!=0 & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)).
- hit_MEM is the same test against rd_MEM/load_MEM, gated by CHECK_MEM. lu = hit_EX | hit_MEM.
- FSM states: IDLE, LOAD_STALL, FLUSHING. The counter width is sized for 7.
- Output priority is combinational, every cycle:
  1. branch_taken: flush=1, cause=0xF, stalls=0.
  2. else lu or state==LOAD_STALL: both stalls=1, cause=0x1.
  3. else state==FLUSHING: flush=1, cause=0xF.
  4. else branch_ID: both stalls=1, cause=0xB.
  5. else all 0.
- Transitions (posedge clock):
  - branch_taken in any state: if FLUSH_EXTRA>0, go to FLUSHING with counter=FLUSH_EXTRA; otherwise go to IDLE. Any pending stall is discarded.
  - IDLE with lu and LOAD_EXTRA>0: go to LOAD_STALL with counter=LOAD_EXTRA.
  - LOAD_STALL: counter decrements. When counter==1, go to IDLE.
  - LOAD_STALL when a new lu occurs: reload counter=LOAD_EXTRA. The stall restarts and does not stack.
  - FLUSHING: counter decrements. When counter==1, go to IDLE.
- Load-use total stall length = 1 + LOAD_EXTRA cycles. Stall asserts in the same cycle as detection (zero latency).
- Branch stall is level-driven: it is held while branch_ID=1 and the higher priorities are idle.
- busy=1 when the state is not IDLE.
- rd==x0 never causes a stall. An unused rs field never causes a stall.
- Reset mid-stall or mid-flush: immediate return to IDLE with outputs 0.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0], perf_branch_cnt[31:0] and perf_flush_cnt[31:0].
  - Each counter increments once per cycle in which cause is 0x1, 0xB or 0xF respectively.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports are absent and there is no counter logic.

Decomposition:
- Package hazard_pkg holds:
  - the FSM state enum (IDLE/LOAD_STALL/FLUSHING);
  - cause constants CAUSE_NONE=4'h0, CAUSE_LOAD=4'h1, CAUSE_BRANCH=4'hB, CAUSE_FLUSH=4'hF;
  - the counter width constant.
- One sub-module, hazard_match: a combinational source/destination comparator, instantiated once for EX and once for MEM.

Test Plan:
1. Load-use stall: LOAD_EXTRA=2, load_EX=1, rd_EX=5, rs1_ID=5, rs1_used=1 for 1 cycle then cleared -> stalls=1 and cause=0x1 for exactly 3 cycles, then 0, busy=0.
2. x0 and unused operands: rd_EX=0 with load_EX=1 and rs1_ID=0 -> no stall. rs2_ID=rd_EX=7 with rs2_used=0 -> no stall.
3. Branch during stall: branch_taken during the 2nd load-stall cycle with FLUSH_EXTRA=1 -> flush=1 that cycle and the next, cause=0xF, stall dropped, then IDLE.
4. Branch stall and reset: branch_ID=1 held 4 cycles -> stalls=1, cause=0xB for 4 cycles. Assert reset mid-stall -> all outputs 0 within the same cycle.
5. MEM check: CHECK_MEM=1, load_MEM=1, rd_MEM=9, rs2_ID=9 -> stall 1+LOAD_EXTRA cycles. With CHECK_MEM=0 -> no stall.
6. Perf counters: with HAZARD_PERF_CNT_EN, run scenario 1 then one flush -> perf_stall_cnt=3, perf_flush_cnt=1, perf_branch_cnt=0.
